// File: rtl/sm_pkg.sv
// Shared sign-magnitude helpers and the S1 stage record for sm_sub_pipe / sm_add_core.
// Magnitude fields are sized for the widest supported word (N up to SM_MAG_W+1); narrower N zero-extends.
package sm_pkg;

  localparam int SM_MAG_W = 31;

  function automatic int sign_idx(input int n);
    return n - 1;
  endfunction

  function automatic logic [SM_MAG_W-1:0] max_mag(input int n);
    logic [SM_MAG_W-1:0] m;
    m = '0;
    for (int i = 0; i < SM_MAG_W; i++) begin
      if (i < n - 1) m[i] = 1'b1;
    end
    return m;
  endfunction

  typedef struct packed {
    logic                sign_a;
    logic                sign_nb;
    logic [SM_MAG_W-1:0] mag_a;
    logic [SM_MAG_W-1:0] mag_b;
    logic                a_gt_b;
    logic                same_sign;
  } sm_s1_t;

endpackage

// File: rtl/sm_sub_pipe_if.sv
// Operand/result handshake bundle for sm_sub_pipe; slave is the pipeline's view.
// N must match the N of the sm_sub_pipe it is connected to.
interface sm_sub_pipe_if #(parameter int N = 8);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_sat;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

endinterface

// File: rtl/sm_add_core.sv
// Combinational sign-magnitude saturating add of an S1 record (operand b already negated).
// Latency 0; no handshake, so no backpressure of its own.
module sm_add_core
  import sm_pkg::*;
#(
  parameter int N = 8
) (
  input  sm_s1_t       s1,
  output logic [N-1:0] data,
  output logic         sat
);

  localparam logic [SM_MAG_W-1:0] MAXM = max_mag(N);

  logic [SM_MAG_W:0]   sum;
  logic [SM_MAG_W-1:0] diff;
  logic [SM_MAG_W-1:0] res_mag;
  logic                res_sign;

  always_comb begin
    sum      = {1'b0, s1.mag_a} + {1'b0, s1.mag_b};
    diff     = s1.a_gt_b ? (s1.mag_a - s1.mag_b) : (s1.mag_b - s1.mag_a);
    sat      = 1'b0;
    res_mag  = diff;
    res_sign = s1.a_gt_b ? s1.sign_a : s1.sign_nb;
    if (s1.same_sign) begin
      res_sign = s1.sign_a;
      if (sum > {1'b0, MAXM}) begin
        res_mag = MAXM;
        sat     = 1'b1;
      end else begin
        res_mag = sum[SM_MAG_W-1:0];
      end
    end
    // Never emit -0: a zero magnitude always carries a positive sign.
    if (res_mag == '0) res_sign = 1'b0;
    data = {res_sign, res_mag[N-2:0]};
  end

endmodule

// File: rtl/sm_sub_pipe.sv
// Two-stage saturating sign-magnitude subtractor a - b; latency 2, 1 result/cycle.
// Backpressure: both stages stall together while out_valid && !out_ready; SM_SAT_STICKY_EN adds sat_sticky/sat_clr.
module sm_sub_pipe
  import sm_pkg::*;
#(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst_n,
`ifdef SM_SAT_STICKY_EN
  input  logic sat_clr,
  output logic sat_sticky,
`endif
  sm_sub_pipe_if.slave io
);

  localparam int SIGN = sign_idx(N);

  logic         en;
  logic         s1_vld;
  sm_s1_t       s1_d;
  sm_s1_t       s1_q;
  logic         s2_vld;
  logic [N-1:0] s2_data;
  logic         s2_sat;
  logic [N-1:0] core_data;
  logic         core_sat;

  assign en          = !s2_vld || io.out_ready;
  assign io.in_ready = en;
  assign io.out_valid = s2_vld;
  assign io.out_data  = s2_data;
  assign io.out_sat   = s2_sat;

  // -0 on either operand is folded to +0 here, so the core only ever sees canonical signs.
  always_comb begin
    s1_d                = '0;
    s1_d.mag_a[N-2:0]   = io.a[N-2:0];
    s1_d.mag_b[N-2:0]   = io.b[N-2:0];
    s1_d.sign_a         = io.a[SIGN] & (|io.a[N-2:0]);
    s1_d.sign_nb        = ~io.b[SIGN] & (|io.b[N-2:0]);
    s1_d.a_gt_b         = s1_d.mag_a > s1_d.mag_b;
    s1_d.same_sign      = s1_d.sign_a == s1_d.sign_nb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_q   <= '0;
    end else if (en) begin
      s1_vld <= io.in_valid;
      s1_q   <= s1_d;
    end
  end

  sm_add_core #(.N(N)) u_core (
    .s1   (s1_q),
    .data (core_data),
    .sat  (core_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld  <= 1'b0;
      s2_data <= '0;
      s2_sat  <= 1'b0;
    end else if (en) begin
      s2_vld  <= s1_vld;
      s2_data <= core_data;
      s2_sat  <= s1_vld & core_sat;
    end
  end

`ifdef SM_SAT_STICKY_EN
  logic sticky_q;

  // A saturated result entering S2 outranks a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (en && s1_vld && core_sat) begin
      sticky_q <= 1'b1;
    end else if (sat_clr) begin
      sticky_q <= 1'b0;
    end
  end

  assign sat_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_sm_sub_pipe.sv
// Randomized and directed checks of sm_sub_pipe against a signed-integer reference model.
// Build with or without SM_SAT_STICKY_EN; the sticky flag is modelled only when defined.
module tb_sm_sub_pipe;

  localparam int N    = 8;
  localparam int MAXV = (1 << (N - 1)) - 1;

  typedef struct {
    logic [N-1:0] d;
    logic         s;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
`ifdef SM_SAT_STICKY_EN
  logic sat_clr;
  logic sat_sticky;
`endif

  sm_sub_pipe_if #(.N(N)) io ();

  sm_sub_pipe #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef SM_SAT_STICKY_EN
    .sat_clr    (sat_clr),
    .sat_sticky (sat_sticky),
`endif
    .io         (io)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_out = 0;
  exp_t q[$];
  logic held = 1'b0;
  logic [N-1:0] h_data;
  logic h_sat;
  logic msticky = 1'b0;
  logic prev_clr = 1'b0;
  logic rdone;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: interpret as signed integers, subtract, clamp to +-MAXV, re-encode.
  function automatic exp_t ref_sub(input logic [N-1:0] x, input logic [N-1:0] y);
    int   va, vb, d;
    exp_t r;
    va = int'(x[N-2:0]);
    if (x[N-1]) va = -va;
    vb = int'(y[N-2:0]);
    if (y[N-1]) vb = -vb;
    d   = va - vb;
    r.s = 1'b0;
    if (d > MAXV) begin d = MAXV; r.s = 1'b1; end
    if (d < -MAXV) begin d = -MAXV; r.s = 1'b1; end
    if (d < 0) r.d = {1'b1, (N-1)'(-d)};
    else       r.d = {1'b0, (N-1)'(d)};
    return r;
  endfunction

  function automatic logic [N-1:0] rnd();
    logic [N-1:0] v;
    v = N'($urandom);
    if ($urandom_range(7) == 0) v[N-2:0] = '0;
    return v;
  endfunction

  // Scoreboard / protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    logic new_res;
    if (!rst_n) begin
      q.delete();
      held     = 1'b0;
      msticky  = 1'b0;
      prev_clr = 1'b0;
    end else begin
      check("in_ready_rule", io.in_ready, !io.out_valid || io.out_ready);
      if (held) begin
        check("hold_valid", io.out_valid, 1);
        check("hold_data", io.out_data, h_data);
        check("hold_sat", io.out_sat, h_sat);
      end
      new_res = io.out_valid && !held;
`ifdef SM_SAT_STICKY_EN
      begin
        logic exp_st;
        exp_st = (new_res && q.size() > 0 && q[0].s) || (msticky && !prev_clr);
        check("sat_sticky", sat_sticky, exp_st);
        msticky  = exp_st;
        prev_clr = sat_clr;
      end
`endif
      if (io.out_valid && io.out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: got %0h expected none at %0t", io.out_data, $time);
        end else begin
          e = q.pop_front();
          check("out_data", io.out_data, e.d);
          check("out_sat", io.out_sat, e.s);
          n_out++;
        end
      end
      held   = io.out_valid && !io.out_ready;
      h_data = io.out_data;
      h_sat  = io.out_sat;
      if (io.in_valid && io.in_ready) q.push_back(ref_sub(io.a, io.b));
    end
  end

  // Called at posedge+1; returns at posedge+1 after the pair was accepted.
  task automatic push(input logic [N-1:0] xa, input logic [N-1:0] xb);
    logic acc;
    int   t;
    io.in_valid = 1'b1;
    io.a        = xa;
    io.b        = xb;
    t           = 0;
    forever begin
      @(negedge clk);
      acc = io.in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      t++;
      if (t > 200) begin
        n_cmp++;
        n_err++;
        $display("FAIL push_timeout: got in_ready low for %0d cycles expected acceptance", t);
        break;
      end
    end
    io.in_valid = 1'b0;
  endtask

  // Directed pair into an empty pipe with out_ready=1: pins the model and the 2-cycle latency.
  task automatic lit(input logic [N-1:0] xa, input logic [N-1:0] xb,
                     input logic [N-1:0] ed, input logic es);
    exp_t m;
    m = ref_sub(xa, xb);
    check("model_data", m.d, ed);
    check("model_sat", m.s, es);
    io.in_valid = 1'b1;
    io.a        = xa;
    io.b        = xb;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    check("lat_not_1", io.out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_2_valid", io.out_valid, 1);
    check("lit_data", io.out_data, ed);
    check("lit_sat", io.out_sat, es);
  endtask

  task automatic drain();
    io.out_ready = 1'b1;
    io.in_valid  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish by 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n        = 1'b0;
    io.in_valid  = 1'b0;
    io.a         = '0;
    io.b         = '0;
    io.out_ready = 1'b1;
    rdone        = 1'b0;
`ifdef SM_SAT_STICKY_EN
    sat_clr = 1'b0;
`endif
    #3;
    check("rst_out_valid", io.out_valid, 0);
    check("rst_out_data", io.out_data, 0);
    check("rst_out_sat", io.out_sat, 0);
    check("rst_in_ready", io.in_ready, 1);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    lit(8'h05, 8'h03, 8'h02, 1'b0);
    lit(8'h03, 8'h05, 8'h82, 1'b0);
    lit(8'h64, 8'hE4, 8'h7F, 1'b1);
    lit(8'hE4, 8'h64, 8'hFF, 1'b1);
    lit(8'h7F, 8'hFF, 8'h7F, 1'b1);
    lit(8'h85, 8'h85, 8'h00, 1'b0);
    lit(8'h80, 8'h00, 8'h00, 1'b0);
    lit(8'h00, 8'h80, 8'h00, 1'b0);
    drain();

`ifdef SM_SAT_STICKY_EN
    check("sticky_held", sat_sticky, 1);
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    check("sticky_cleared", sat_sticky, 0);
`endif

    // Back-pressure: 6 pairs back-to-back with a 3-cycle stall mid-stream.
    base = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++) push(rnd(), rnd());
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        io.out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", io.in_ready, 0);
          check("stall_out_valid", io.out_valid, 1);
        end
        @(posedge clk);
        #1;
        io.out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", n_out - base, 6);

    // Bubbles: in_valid 1/0 gives out_valid 1/0 two cycles later.
    for (int k = 0; k < 10; k++) begin
      io.in_valid = (k < 6) && (k % 2 == 0);
      io.a        = rnd();
      io.b        = rnd();
      @(negedge clk);
      check("bubble_valid", io.out_valid, (k >= 2) && (k - 2 < 6) && ((k - 2) % 2 == 0));
      @(posedge clk);
      #1;
    end
    drain();

    // Asynchronous reset with both stages full.
    io.in_valid = 1'b1;
    io.a        = 8'h64;
    io.b        = 8'hE4;
    @(posedge clk);
    #1;
    io.a = 8'h11;
    io.b = 8'h22;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    check("pre_rst_valid", io.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", io.out_valid, 0);
    check("arst_out_data", io.out_data, 0);
    check("arst_out_sat", io.out_sat, 0);
`ifdef SM_SAT_STICKY_EN
    check("arst_sticky", sat_sticky, 0);
`endif
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", io.in_ready, 1);
    check("post_rst_out_valid", io.out_valid, 0);
    lit(8'h05, 8'h03, 8'h02, 1'b0);
    drain();

    // Randomized traffic with random downstream stalls.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
          end
          push(rnd(), rnd());
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #1;
          io.out_ready = ($urandom_range(2) != 0);
`ifdef SM_SAT_STICKY_EN
          sat_clr = ($urandom_range(5) == 0);
`endif
        end
      end
    join
`ifdef SM_SAT_STICKY_EN
    sat_clr = 1'b0;
`endif
    drain();
    check("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
